// File: rtl/sap3_mem_pkg.sv
// Shared types and constants for the SAP-3 memory-side responder.
// Sequencer states and the default bus/data widths.
package sap3_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } mem_state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/sap3_mem_array.sv
// DEPTH x 8 RAM with one write port and one registered, write-first read port.
module sap3_mem_array
  import sap3_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; a same-edge write to the read address forwards the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (we && (waddr == raddr)) begin
      rdata_r <= wdata;
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sap3_mem_responder.sv
// Memory end of the SAP-3 external bus: clear/preload sequencer, MAR, RAM
// write-port mux and sticky protocol-error flags. Holds the CPU in reset until RUN.
module sap3_mem_responder
  import sap3_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit CLR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        bus_lo,
  input  logic [7:0]        bus_hi,
  input  logic              mem_mar_we,
  input  logic              mem_ram_we,
  output logic [7:0]        mem_out,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              cpu_rst_n,
  output logic              err_collide,
  output logic              err_oor
);

  localparam int AW = $clog2(DEPTH);
  localparam mem_state_t RST_STATE = CLR_EN ? ST_CLEAR : ST_LOAD;

  mem_state_t        state_r, state_next_s;
  logic [AW-1:0]     mar_r, mar_next_s;
  logic [AW-1:0]     clr_cnt_r, clr_cnt_next_s;
  logic              load_ready_r, cpu_rst_n_r;
  logic              err_collide_r, err_oor_r;
  logic              we_s, collide_s, oor_s;
  logic [AW-1:0]     waddr_s;
  logic [7:0]        wdata_s;
  logic [15:0]       bus_s;
  logic              unused_s;

  assign bus_s    = {bus_hi, bus_lo};
  assign unused_s = ^load_addr;

  // Next-state, MAR update and write-port selection for each phase.
  always_comb begin
    state_next_s   = state_r;
    mar_next_s     = mar_r;
    clr_cnt_next_s = clr_cnt_r;
    we_s           = 1'b0;
    waddr_s        = mar_r;
    wdata_s        = 8'h00;
    collide_s      = 1'b0;
    oor_s          = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        we_s           = 1'b1;
        waddr_s        = clr_cnt_r;
        clr_cnt_next_s = clr_cnt_r + AW'(1);
        if (clr_cnt_r == AW'(DEPTH - 1)) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready_r) begin
          we_s    = 1'b1;
          waddr_s = load_addr[AW-1:0];
          wdata_s = load_data;
          if (load_last) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        // An address capture pre-empts a same-cycle RAM write.
        if (mem_mar_we) begin
          mar_next_s = bus_s[AW-1:0];
          oor_s      = ({1'b0, bus_s} >= 17'(DEPTH));
          collide_s  = mem_ram_we;
        end else if (mem_ram_we) begin
          we_s    = 1'b1;
          waddr_s = mar_r;
          wdata_s = bus_lo;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        state_next_s = RST_STATE;
      end
    endcase
  end

  // Sequencer, MAR, handshake/CPU-reset outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RST_STATE;
      mar_r         <= {AW{1'b0}};
      clr_cnt_r     <= {AW{1'b0}};
      load_ready_r  <= 1'b0;
      cpu_rst_n_r   <= 1'b0;
      err_collide_r <= 1'b0;
      err_oor_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      mar_r         <= mar_next_s;
      clr_cnt_r     <= clr_cnt_next_s;
      load_ready_r  <= (state_next_s == ST_LOAD);
      cpu_rst_n_r   <= (state_next_s == ST_RUN);
      err_collide_r <= err_collide_r | collide_s;
      err_oor_r     <= err_oor_r | oor_s;
    end
  end

  sap3_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (mar_next_s),
    .rdata (mem_out)
  );

  assign load_ready  = load_ready_r;
  assign cpu_rst_n   = cpu_rst_n_r;
  assign err_collide = err_collide_r;
  assign err_oor     = err_oor_r;

endmodule
